load_extend_unit: RTL and testbench
===================================

Name: load_extend_unit

Overview:
- Pipelined load-data alignment and extension stage between the data-memory read port and register-file writeback.
- Selects the addressed byte, halfword or word from a memory word, then sign- or zero-extends it to the full data width.
- Carries a destination tag and uses a valid/ready handshake with a skid buffer, so writeback stalls never drop loads.
- Generalises 8-bit extension to 8/16/32(/64)-bit lanes with byte-offset alignment.

Parameters:
- DATA_W, 32, memory word and result width; legal values are 32 or 64.
- TAG_W, 5, width of the passthrough destination-register tag.
- OFF_W, $clog2(DATA_W/8), byte-offset width (localparam, derived).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  load data present
- in_ready  out  1  unit can accept this cycle
- in_data  in  DATA_W  raw memory word, little-endian (byte k = bits [8k+7:8k])
- in_off  in  OFF_W  byte offset of the access within the word
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64)
- in_sign  in  1  1=sign-extend, 0=zero-extend
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  aligned, extended result
- out_tag  out  TAG_W  tag of out_data
- out_err  out  1  misalignment flag (feature-dependent)

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_tag=0, out_err=0, skid empty, in_ready=1. Deassertion is sampled on the next clk edge.
- Datapath per item:
  - lane width L = 8<<in_size.
  - Start byte = in_off rounded down to a multiple of L/8.
  - field = in_data[start*8 +: L].
  - Result = field extended by {DATA_W-L{in_sign & field[L-1]}}.
  - Word size on DATA_W=32, or dword on 64, passes in_data through unchanged.
  - in_size=3 with DATA_W=32 is treated as word.
- Latency: exactly 1 cycle from acceptance to out_valid when the output is free. Results are computed combinationally and registered.
- Storage: output register plus one skid register; maximum 2 items in flight.
- in_ready is a registered signal, equal to NOT skid_valid; it never depends combinationally on out_ready.
- Accept condition: in_valid & in_ready.
- Output register load, when it is empty or out_ready=1:
  - Takes the skid entry if the skid is valid; the skid then empties.
  - Otherwise takes the accepted input.
  - Otherwise out_valid falls to 0.
- Skid load: an accepted item goes to the skid when the output holds valid data and out_ready=0.
- Stall hold: while out_valid=1 and out_ready=0, out_data, out_tag and out_err are held stable.
- Ordering is strictly FIFO.
- Full throughput: with out_ready held at 1, one item per cycle and in_ready stays 1.
- Simultaneous events: skid drains to output and a new item is accepted in the same cycle. The new item goes to the skid only if the output stays occupied; otherwise the output reloads from the skid and the new item is blocked, because in_ready was 0.
- Reset mid-stall: all buffered items are discarded and nothing is emitted afterwards.

Optional Feature:
- Macro: LOAD_EXT_MISALIGN_TRAP_EN.
- Defined: out_err=1 when in_off is not a multiple of L/8. Data is still produced using the rounded-down start, and out_err travels with its item through the skid.
- Undefined: out_err is tied to 0 and no misalignment logic is synthesised. Rounding-down alignment is unchanged.

Decomposition:
- Shared package ldext_pkg holds:
  - size encoding constants LD_BYTE=2'd0, LD_HALF=2'd1, LD_WORD=2'd2, LD_DWORD=2'd3;
  - lane-width function lane_bits(size).
- One natural sub-module, ldext_align: purely combinational selection and extension of one item, instanced once in front of the registers.
- The handshake, skid and register logic stays in load_extend_unit.

Test Plan:
- DATA_W=32, data 0x8034_F0A5, off=1, byte, sign=1, tag=7 -> next cycle out_data 0xFFFF_FFF0, out_tag 7, out_err 0.
- Same data, off=2, half, sign=0 -> 0x0000_8034; with sign=1 -> 0xFFFF_8034.
- Back-to-back 4 items with out_ready=1 -> 4 consecutive out_valid cycles, in order, in_ready never low.
- out_ready=0 for 3 cycles while 3 items are offered -> 2 accepted, in_ready low from the 3rd cycle, no data change at output. Releasing out_ready yields items 1 and 2 in order, then item 3 is accepted.
- With LOAD_EXT_MISALIGN_TRAP_EN: half at off=3 -> out_err=1, data from bytes 2–3. Without the macro -> out_err=0, same data.
- DATA_W=64, data 0xFEDC_BA98_7654_3210, word, off=4, sign=1 -> 0xFFFF_FFFF_FEDC_BA98. Asserting rst_n=0 while stalled -> out_valid=0 immediately and in_ready=1.

Source files
------------

// File: rtl/ldext_pkg.sv
// ----------------------------------------------------------------------------
// ldext_pkg
// Shared definitions for the load-extend unit.
//   LD_BYTE / LD_HALF / LD_WORD / LD_DWORD : in_size encodings
//   lane_bits(size)                        : width in bits of a load lane
// ----------------------------------------------------------------------------
package ldext_pkg;

    localparam logic [1:0] LD_BYTE  = 2'd0;
    localparam logic [1:0] LD_HALF  = 2'd1;
    localparam logic [1:0] LD_WORD  = 2'd2;
    localparam logic [1:0] LD_DWORD = 2'd3;

    // Lane width L = 8 << size (8, 16, 32 or 64 bits).
    function automatic int unsigned lane_bits(input logic [1:0] size);
        return 32'd8 << size;
    endfunction

endpackage

// File: rtl/ldext_align.sv
// ----------------------------------------------------------------------------
// ldext_align
// Purely combinational selection and extension of one load item.
//   data   in  DATA_W  raw little-endian memory word
//   off    in  OFF_W   byte offset of the access
//   size   in  2       LD_BYTE / LD_HALF / LD_WORD / LD_DWORD
//   sign   in  1       1 = sign-extend, 0 = zero-extend
//   result out DATA_W  aligned, extended value
//   err    out 1       offset not a multiple of the lane size
//                      (port present only with LOAD_EXT_MISALIGN_TRAP_EN)
// Optional feature macro: LOAD_EXT_MISALIGN_TRAP_EN
// ----------------------------------------------------------------------------
module ldext_align
    import ldext_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sign,
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] result
);

    // Offset bits that must be zero for an aligned access of this size.
    // On a 32-bit word a dword request saturates to the all-ones mask,
    // which is exactly the word mask, so it behaves as a word load.
    logic [OFF_W-1:0]  align_mask;
    logic [OFF_W-1:0]  start_byte;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] cand [4];

    always_comb begin
        align_mask = '1;
        case (size)
            LD_BYTE: align_mask = '0;
            LD_HALF: align_mask = OFF_W'(1);
            LD_WORD: align_mask = OFF_W'(3);
            default: align_mask = '1;
        endcase
    end

    // Round the offset down to the lane boundary, then bring the lane to bit 0.
    assign start_byte = off & ~align_mask;
    assign shifted    = data >> {start_byte, 3'b000};

    // One extended candidate per lane size; a lane as wide as the word (or
    // wider, i.e. dword on a 32-bit build) passes the shifted word through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int LB = int'(lane_bits(2'(gi)));
            if (LB < DATA_W) begin : g_ext
                assign cand[gi] = {{(DATA_W-LB){sign & shifted[LB-1]}},
                                   shifted[LB-1:0]};
            end else begin : g_full
                assign cand[gi] = shifted;
            end
        end
    endgenerate

    assign result = cand[size];

`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    assign err = |(off & align_mask);
`endif

endmodule

// File: rtl/load_extend_unit.sv
// ----------------------------------------------------------------------------
// load_extend_unit
// Pipelined load-data alignment / extension stage with valid/ready handshake
// and a one-entry skid buffer (output register + skid = 2 items max).
//   clk       in  1       rising-edge clock
//   rst_n     in  1       asynchronous active-low reset
//   in_valid  in  1       load data present
//   in_ready  out 1       unit can accept (registered, = !skid valid)
//   in_data   in  DATA_W  raw memory word, little-endian
//   in_off    in  OFF_W   byte offset within the word
//   in_size   in  2       0=byte 1=half 2=word 3=dword
//   in_sign   in  1       1=sign-extend 0=zero-extend
//   in_tag    in  TAG_W   destination tag
//   out_valid out 1       result valid
//   out_ready in  1       downstream accepts
//   out_data  out DATA_W  aligned, extended result
//   out_tag   out TAG_W   tag of out_data
//   out_err   out 1       misalignment flag (0 unless feature enabled)
// Optional feature macro: LOAD_EXT_MISALIGN_TRAP_EN
// ----------------------------------------------------------------------------
module load_extend_unit
    import ldext_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    logic [DATA_W-1:0] align_result;

    logic              out_valid_reg,  out_valid_next;
    logic [DATA_W-1:0] out_data_reg,   out_data_next;
    logic [TAG_W-1:0]  out_tag_reg,    out_tag_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [TAG_W-1:0]  skid_tag_reg,   skid_tag_next;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    logic              align_err;
    logic              out_err_reg,    out_err_next;
    logic              skid_err_reg,   skid_err_next;
`endif

    logic accept;
    logic out_free;

    ldext_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .data   (in_data),
        .off    (in_off),
        .size   (in_size),
        .sign   (in_sign),
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
        .err    (align_err),
`endif
        .result (align_result)
    );

    // in_ready comes straight from a flop, so it never sees out_ready.
    assign in_ready = ~skid_valid_reg;
    assign accept   = in_valid & in_ready;
    // The output register may load this cycle if it is empty or draining.
    assign out_free = ~out_valid_reg | out_ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_tag_next    = out_tag_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_tag_next   = skid_tag_reg;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
        out_err_next    = out_err_reg;
        skid_err_next   = skid_err_reg;
`endif
        if (out_free) begin
            if (skid_valid_reg) begin
                // Skid holds the oldest item; in_ready is low so nothing
                // new can be accepted this cycle.
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                out_tag_next    = skid_tag_reg;
                skid_valid_next = 1'b0;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
                out_err_next    = skid_err_reg;
`endif
            end else if (accept) begin
                out_valid_next  = 1'b1;
                out_data_next   = align_result;
                out_tag_next    = in_tag;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
                out_err_next    = align_err;
`endif
            end else begin
                // Payload is left as-is; only the valid bit drops.
                out_valid_next  = 1'b0;
            end
        end else if (accept) begin
            // Output is stalled with valid data: park the new item.
            skid_valid_next = 1'b1;
            skid_data_next  = align_result;
            skid_tag_next   = in_tag;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
            skid_err_next   = align_err;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_tag_reg    <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_tag_reg   <= '0;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
            out_err_reg    <= 1'b0;
            skid_err_reg   <= 1'b0;
`endif
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_tag_reg    <= out_tag_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_tag_reg   <= skid_tag_next;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
            out_err_reg    <= out_err_next;
            skid_err_reg   <= skid_err_next;
`endif
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_tag   = out_tag_reg;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    assign out_err   = out_err_reg;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_extend_unit.sv
// ----------------------------------------------------------------------------
// tb_load_extend_unit
// Drives a 32-bit and a 64-bit load_extend_unit in lockstep with the same
// handshake stimulus; each has its own expected-result queue produced by a
// byte-level reference model.
// ----------------------------------------------------------------------------
module tb_load_extend_unit;

`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  t;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_size;
    logic        in_sign;
    logic [4:0]  in_tag;
    logic [31:0] in_data32;
    logic [1:0]  in_off32;
    logic [63:0] in_data64;
    logic [2:0]  in_off64;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_data32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_data64;
    logic [4:0]  out_tag64;

    int total = 0;
    int bad   = 0;

    exp_t q32[$];
    exp_t q64[$];
    bit          stall32 = 1'b0, stall64 = 1'b0;
    logic [31:0] held32;
    logic [63:0] held64;

    always #5 clk = ~clk;

    load_extend_unit #(.DATA_W(32), .TAG_W(5)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_data(in_data32), .in_off(in_off32), .in_size(in_size),
        .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_tag(out_tag32), .out_err(out_err32)
    );

    load_extend_unit #(.DATA_W(64), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_data(in_data64), .in_off(in_off64), .in_size(in_size),
        .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_data(out_data64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: gather the lane bytes from the rounded-down start byte, then
    // fill the upper bits with the lane's top bit when sign-extending.
    function automatic logic [63:0] ref_load(input logic [63:0] d, input int off,
                                             input int sz, input bit sg,
                                             input int dw, output bit mis);
        int nb;
        int start;
        logic [63:0] v;
        nb = 1 << sz;
        if (nb * 8 > dw) nb = dw / 8;
        start = (off / nb) * nb;
        mis   = (off % nb) != 0;
        v     = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(start+i) +: 8];
        if (sg && v[8*nb-1]) for (int b = 8*nb; b < dw; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic observe();
        exp_t e;
        bit   mis;
        // 32-bit instance
        if (stall32) begin
            chk("hold_valid32", {63'd0, out_valid32}, 64'd1);
            chk("hold_data32", {32'd0, out_data32}, {32'd0, held32});
        end
        if (out_valid32 && out_ready) begin
            chk("q32_nonempty", {63'd0, q32.size() != 0}, 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                $display("out32 tag=%0d data=%h err=%0b", out_tag32, out_data32, out_err32);
                chk("data32", {32'd0, out_data32}, e.d);
                chk("tag32", {59'd0, out_tag32}, {59'd0, e.t});
                chk("err32", {63'd0, out_err32}, {63'd0, e.e});
            end
        end
        if (in_valid && in_ready32) begin
            e.d = ref_load({32'd0, in_data32}, int'(in_off32), int'(in_size), in_sign, 32, mis);
            e.t = in_tag;
            e.e = TRAP_EN & mis;
            q32.push_back(e);
        end
        stall32 = out_valid32 && !out_ready;
        held32  = out_data32;
        // 64-bit instance
        if (stall64) begin
            chk("hold_valid64", {63'd0, out_valid64}, 64'd1);
            chk("hold_data64", out_data64, held64);
        end
        if (out_valid64 && out_ready) begin
            chk("q64_nonempty", {63'd0, q64.size() != 0}, 64'd1);
            if (q64.size() != 0) begin
                e = q64.pop_front();
                $display("out64 tag=%0d data=%h err=%0b", out_tag64, out_data64, out_err64);
                chk("data64", out_data64, e.d);
                chk("tag64", {59'd0, out_tag64}, {59'd0, e.t});
                chk("err64", {63'd0, out_err64}, {63'd0, e.e});
            end
        end
        if (in_valid && in_ready64) begin
            e.d = ref_load(in_data64, int'(in_off64), int'(in_size), in_sign, 64, mis);
            e.t = in_tag;
            e.e = TRAP_EN & mis;
            q64.push_back(e);
        end
        stall64 = out_valid64 && !out_ready;
        held64  = out_data64;
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later.
    task automatic tick(input bit v, input logic [63:0] d, input int off,
                        input logic [1:0] sz, input bit sg, input logic [4:0] tg,
                        input bit ordy);
        logic [2:0] o;
        @(negedge clk);
        o         = 3'(off);
        in_valid  = v;
        in_data64 = d;
        in_data32 = d[31:0];
        in_off64  = o;
        in_off32  = o[1:0];
        in_size   = sz;
        in_sign   = sg;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        observe();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data32 = '0; in_off32 = '0; in_data64 = '0; in_off64 = '0;
        in_size = 2'd0; in_sign = 1'b0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready32}, 64'd1);
        chk("rst_out_data", {32'd0, out_data32}, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag32}, 64'd0);
        chk("rst_out_err", {63'd0, out_err32}, 64'd0);
        chk("rst_out_data64", out_data64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte at offset 1, sign-extended.
        tick(1, 64'h8034_F0A5, 1, 2'd0, 1, 5'd7, 1);
        after_edge();
        chk("byte_sx_valid", {63'd0, out_valid32}, 64'd1);
        chk("byte_sx_data", {32'd0, out_data32}, 64'hFFFF_FFF0);
        chk("byte_sx_tag", {59'd0, out_tag32}, 64'd7);
        chk("byte_sx_err", {63'd0, out_err32}, 64'd0);
        // Half at offset 2, zero then sign extension.
        tick(1, 64'h8034_F0A5, 2, 2'd1, 0, 5'd8, 1);
        after_edge();
        chk("half_zx_data", {32'd0, out_data32}, 64'h0000_8034);
        tick(1, 64'h8034_F0A5, 2, 2'd1, 1, 5'd9, 1);
        after_edge();
        chk("half_sx_data", {32'd0, out_data32}, 64'hFFFF_8034);
        // Misaligned half at offset 3 uses bytes 2-3.
        tick(1, 64'h8034_F0A5, 3, 2'd1, 0, 5'd10, 1);
        after_edge();
        chk("mis_data", {32'd0, out_data32}, 64'h0000_8034);
        chk("mis_err", {63'd0, out_err32}, {63'd0, TRAP_EN});
        // Word at offset 4 on the 64-bit instance.
        tick(1, 64'hFEDC_BA98_7654_3210, 4, 2'd2, 1, 5'd11, 1);
        after_edge();
        chk("w64_data", out_data64, 64'hFFFF_FFFF_FEDC_BA98);
        chk("w64_err", {63'd0, out_err64}, 64'd0);
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);

        // Back-to-back with out_ready high: in_ready never drops.
        for (int i = 0; i < 4; i++) begin
            tick(1, {$urandom, $urandom}, i, 2'(i), i[0], 5'(20 + i), 1);
            chk("b2b_in_ready", {63'd0, in_ready32}, 64'd1);
        end
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);
        chk("b2b_last_valid", {63'd0, out_valid32}, 64'd1);
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);
        chk("b2b_drained", {63'd0, out_valid32}, 64'd0);

        // Stall: three offered, two taken, third blocked until release.
        tick(1, 64'h1111_2222_3333_4444, 0, 2'd2, 0, 5'd1, 0);
        tick(1, 64'h5555_6666_7777_8888, 0, 2'd2, 0, 5'd2, 0);
        tick(1, 64'h9999_AAAA_BBBB_CCCC, 0, 2'd2, 0, 5'd3, 0);
        chk("stall_in_ready", {63'd0, in_ready32}, 64'd0);
        chk("stall_data", {32'd0, out_data32}, 64'h3333_4444);
        chk("stall_tag", {59'd0, out_tag32}, 64'd1);
        tick(1, 64'h9999_AAAA_BBBB_CCCC, 0, 2'd2, 0, 5'd3, 1);
        chk("rel_tag1", {59'd0, out_tag32}, 64'd1);
        tick(1, 64'h9999_AAAA_BBBB_CCCC, 0, 2'd2, 0, 5'd3, 1);
        chk("rel_tag2", {59'd0, out_tag32}, 64'd2);
        chk("rel_in_ready", {63'd0, in_ready32}, 64'd1);
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);
        chk("rel_tag3", {59'd0, out_tag32}, 64'd3);
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);

        // Reset while stalled with both registers full.
        tick(1, 64'hAAAA_0001, 0, 2'd2, 0, 5'd4, 0);
        tick(1, 64'hAAAA_0002, 0, 2'd2, 0, 5'd5, 0);
        tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid32", {63'd0, out_valid32}, 64'd0);
        chk("rstmid_ready32", {63'd0, in_ready32}, 64'd1);
        chk("rstmid_valid64", {63'd0, out_valid64}, 64'd0);
        chk("rstmid_ready64", {63'd0, in_ready64}, 64'd1);
        q32.delete(); q64.delete();
        stall32 = 1'b0; stall64 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);
            chk("post_rst_idle", {63'd0, out_valid32 | out_valid64}, 64'd0);
        end

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, {$urandom, $urandom}, int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) tick(0, 64'd0, 0, 2'd0, 0, 5'd0, 1);
        chk("drain_q32", 64'(q32.size()), 64'd0);
        chk("drain_q64", 64'(q64.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
